reg_dump_streamer: RTL
======================

// Module: reg_dump_streamer
// PURPOSE
//  Debug-side consumer of the Pipeline register file. On a start pulse it walks
//  regs[0..REG_CNT-1] through a 1-cycle-latency read port and serializes them
//  into a byte stream with a valid/ready handshake, framed by a sync header and
//  an XOR checksum. It sits beside Reg_File_Inst and feeds the board UART TX, so
//  the hardware gets the same register dump that the simulation bench writes.
// PARAMETERS
//  XLEN      `XLEN_32b  width code; data width W = 1<<(XLEN+4) (32 or 64)
//  REG_CNT   `REG_CNT   number of registers dumped (32)
//  SYNC_BYTE 8'hA5      frame header byte
// PORTS
//  i_clk          in   1      system clock, all logic on rising edge
//  i_rst          in   1      synchronous active-high reset
//  i_start        in   1      dump request; sampled only in IDLE
//  o_busy         out  1      high from the cycle after start acceptance until DONE
//  o_done         out  1      one-cycle pulse after the checksum byte is accepted
//  o_reg_rd_en    out  1      register read strobe
//  o_reg_addr     out  5      register index to read
//  i_reg_rd_data  in   W      read data, valid the cycle after o_reg_rd_en
//  o_byte_valid   out  1      stream byte valid
//  o_byte_data    out  8      stream byte
//  o_byte_last    out  1      high with the checksum byte (last byte of frame)
//  i_byte_ready   in   1      sink accepts the byte when valid && ready
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; reg index, byte counter and checksum = 0.
//   A reset mid-frame aborts the frame immediately: valid drops the next cycle,
//   and no done pulse is generated.
//  FSM: IDLE -> HDR -> RD -> CAP -> SEND -> (RD | CSUM) -> DONE -> IDLE.
//   IDLE: if i_start, clear index and checksum, then go to HDR. A start while not
//    IDLE is ignored; it is neither queued nor does it restart the frame.
//   HDR: valid=1, data=SYNC_BYTE; go to RD on acceptance.
//   RD: rd_en=1, addr=index, for exactly one cycle; go to CAP.
//   CAP: latch i_reg_rd_data into a W-bit shift register, set byte counter=W/8.
//   SEND: valid=1, data = shift register MSB byte (big-endian). On acceptance:
//    checksum ^= byte, shift left 8, counter-1. When the last byte of a register
//    is accepted: if index==REG_CNT-1 go to CSUM, else index+1 and go to RD.
//   CSUM: valid=1, last=1, data=checksum; go to DONE on acceptance.
//   DONE: o_done=1 for one cycle, busy=0; go to IDLE. A new start is accepted
//    no earlier than the IDLE cycle that follows.
//  Handshake: once valid is asserted, data and last hold stable until accepted;
//   valid never drops without acceptance except on reset. A byte is transferred
//   only when valid && ready are high at the clock edge. Ready may be held low
//   indefinitely (no timeout). Back-to-back acceptance sends 1 byte per cycle.
//  Frame length: 2 + REG_CNT*W/8 bytes (130 for 32b, 258 for 64b). The checksum
//   covers register bytes only, not the header.
//  Latency (ready held high): start sampled at edge N -> header valid in N+1;
//   first rd_en in N+2; 32b frame done in N+1+REG_CNT*(2+4)+1 cycles.
//  Register index width is 5 bits; it never wraps past REG_CNT-1.
//  regs[0] is read and sent like any other register; no special case.
// TESTING
//  1 regs all 0 except regs[31]=2, ready=1 -> 130 bytes: A5, 127x00, 02, 02;
//    last only on byte 130; one done pulse; busy low after.
//  2 regs[i]=i, 32b -> regs[5] sent as 00,00,00,05; checksum = 0x00 (XOR 0..31).
//  3 random ready toggling (~50%) -> byte sequence identical to case 2; data and
//    last never change while valid && !ready.
//  4 i_start pulsed at frame byte 40 -> ignored; exactly one 130-byte frame and
//    one done pulse.
//  5 i_rst during SEND with ready=0 -> next cycle valid=0, busy=0, no done; a
//    later start sends a full, correct frame that begins with A5.
//  6 XLEN=`XLEN_64b, regs[1]=64'h0123456789ABCDEF -> bytes 01..EF, MSB first;
//    frame = 258 bytes.

Source files
------------

// File: rtl/reg_dump_streamer.sv
// -----------------------------------------------------------------------------
// reg_dump_streamer
//
// Purpose:
//   On a start pulse, walks regs[0..REG_CNT-1] through a 1-cycle-latency
//   register read port and serializes them into a byte stream. The frame is:
//     SYNC_BYTE, then every register MSB byte first, then an XOR checksum
//     of the register bytes only. The sync header is not included in the
//     checksum.
//
// Parameters:
//   XLEN      width code; data width W = 1 << (XLEN + 4)  (1 -> 32b, 2 -> 64b)
//   REG_CNT   number of registers dumped (at most 32)
//   SYNC_BYTE frame header byte
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous active-high reset; aborts any frame in flight
//   i_start        dump request, only looked at in IDLE
//   o_busy         high from the cycle after start acceptance until DONE
//   o_done         one-cycle pulse after the checksum byte is accepted
//   o_reg_rd_en    register read strobe
//   o_reg_addr     register index to read (0 whenever o_reg_rd_en is low)
//   i_reg_rd_data  read data, valid the cycle after o_reg_rd_en
//   o_byte_valid   stream byte valid
//   o_byte_data    stream byte
//   o_byte_last    marks the checksum byte (last byte of the frame)
//   i_byte_ready   sink ready
//   o_dbg_state    current FSM state encoding (see state_e)
//
// Handshake: a byte moves only on a clock edge where o_byte_valid and
// i_byte_ready are both high. Once valid is raised, data and last are driven
// purely from registers that only change on acceptance, so they hold stable
// until the byte is taken; valid only drops without acceptance on reset.
// Ready may stay low indefinitely.
// -----------------------------------------------------------------------------
module reg_dump_streamer #(
  parameter int         XLEN      = 1,
  parameter int         REG_CNT   = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_reg_rd_en,
  output logic [4:0]                  o_reg_addr,
  input  logic [(1 << (XLEN+4))-1:0]  i_reg_rd_data,
  output logic                        o_byte_valid,
  output logic [7:0]                  o_byte_data,
  output logic                        o_byte_last,
  input  logic                        i_byte_ready,
  output logic [2:0]                  o_dbg_state
);

  localparam int         W        = 1 << (XLEN + 4);
  localparam int         NB       = W / 8;
  localparam logic [3:0] NB_CNT   = 4'(NB);
  localparam logic [4:0] IDX_LAST = 5'(REG_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_SEND = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     csum_q, csum_d;
  logic [W-1:0]   shift_q, shift_d;

  logic           send_fire;
  logic           reg_last_byte;

  assign send_fire     = (state_q == S_SEND) && i_byte_ready;
  assign reg_last_byte = (cnt_q == 4'd1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      shift_q <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_HDR;
      S_HDR:  if (i_byte_ready) state_d = S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = S_SEND;
      S_SEND: begin
        if (send_fire && reg_last_byte) begin
          state_d = (idx_q == IDX_LAST) ? S_CSUM : S_RD;
        end
      end
      S_CSUM: if (i_byte_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d  = '0;
          csum_d = '0;
        end
      end
      S_CAP: begin
        shift_d = i_reg_rd_data;
        cnt_d   = NB_CNT;
      end
      S_SEND: begin
        if (send_fire) begin
          csum_d  = csum_q ^ shift_q[W-1 -: 8];
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - 4'd1;
          // Index stops at the last register instead of wrapping.
          if (reg_last_byte && (idx_q != IDX_LAST)) idx_d = idx_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_reg_rd_en  = 1'b0;
    o_reg_addr   = '0;
    o_byte_valid = 1'b0;
    o_byte_data  = '0;
    o_byte_last  = 1'b0;
    case (state_q)
      S_HDR: begin
        o_busy       = 1'b1;
        o_byte_valid = 1'b1;
        o_byte_data  = SYNC_BYTE;
      end
      S_RD: begin
        o_busy      = 1'b1;
        o_reg_rd_en = 1'b1;
        o_reg_addr  = idx_q;
      end
      S_CAP: o_busy = 1'b1;
      S_SEND: begin
        o_busy       = 1'b1;
        o_byte_valid = 1'b1;
        o_byte_data  = shift_q[W-1 -: 8];
      end
      S_CSUM: begin
        o_busy       = 1'b1;
        o_byte_valid = 1'b1;
        o_byte_last  = 1'b1;
        o_byte_data  = csum_q;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_dbg_state = state_q;

endmodule
